// File: rtl/tmr_cnt_ctrl.sv
// Timer counter control sequencer: drives clr/wren/tick strobes to TCNT
// and qualifies its overflow flag into sticky status and an interrupt line.
// Ports:
//   i_clk_sys, i_rst        clock, synchronous active-high reset
//   i_en, i_load            run enable level, load strobe
//   i_clk_sel               prescaler divide select (ratio 2^(sel+1))
//   i_ovf, i_ovf_clr        raw counter overflow, W1C status clear
//   i_ovf_ie                overflow interrupt enable
//   o_cnt_clr/wren/tick     mutually exclusive counter strobes
//   o_ovf_sts, o_irq        sticky overflow status, interrupt
//   o_state                 FSM state (IDLE=0 LOAD=1 RUN=2 STOP=3)
module tmr_cnt_ctrl #(
  parameter int PSC_SEL_W   = 2,
  parameter int PSC_W       = 4,
  parameter bit CLR_ON_STOP = 1'b1
) (
  input  logic                 i_clk_sys,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_load,
  input  logic [PSC_SEL_W-1:0] i_clk_sel,
  input  logic                 i_ovf,
  input  logic                 i_ovf_clr,
  input  logic                 i_ovf_ie,
  output logic                 o_cnt_clr,
  output logic                 o_cnt_wren,
  output logic                 o_cnt_tick,
  output logic                 o_ovf_sts,
  output logic                 o_irq,
  output logic [1:0]           o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PSC_W-1:0]     r_psc;
  logic [PSC_W-1:0]     w_psc_nxt;
  logic [PSC_W-1:0]     w_div_m1;
  logic [PSC_SEL_W-1:0] r_sel;
  logic [PSC_SEL_W-1:0] w_sel_nxt;
  logic                 r_mask;
  logic                 r_ovf_sts;
  logic                 w_wren;
  logic                 w_clr;
  logic                 w_tick;
  logic                 w_ovf_q;

  // div-1 = 2^(sel+1)-1: the low sel+1 bits set
  always_comb begin
    w_div_m1 = '0;
    for (int i = 0; i < PSC_W; i++) begin
      w_div_m1[i] = (i <= int'(r_sel));
    end
  end

  // Strobes decode from state/prescaler registers only
  assign w_wren = (r_state == S_LOAD);
  assign w_clr  = (r_state == S_STOP) && CLR_ON_STOP;
  assign w_tick = (r_state == S_RUN) && (r_psc == w_div_m1);

  always_comb begin
    w_state_nxt = r_state;
    w_psc_nxt   = '0;
    w_sel_nxt   = r_sel;
    unique case (r_state)
      S_IDLE: begin
        if (i_load) begin
          w_state_nxt = S_LOAD;
        end else if (i_en) begin
          w_state_nxt = S_RUN;
          w_sel_nxt   = i_clk_sel;
        end
      end
      S_LOAD: begin
        if (i_en) begin
          w_state_nxt = S_RUN;
          w_sel_nxt   = i_clk_sel;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (i_load) begin
          w_state_nxt = S_LOAD;
        end else if (!i_en) begin
          w_state_nxt = S_STOP;
        end else begin
          w_psc_nxt = w_tick ? '0 : r_psc + PSC_W'(1);
        end
      end
      S_STOP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The counter's flag in the cycle after a write/clear may be a false
  // FF->00 transition, so it is masked for that one cycle.
  assign w_ovf_q = i_ovf && !r_mask;

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_psc     <= '0;
      r_sel     <= '0;
      r_mask    <= 1'b0;
      r_ovf_sts <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_psc   <= w_psc_nxt;
      r_sel   <= w_sel_nxt;
      r_mask  <= w_wren || w_clr;
      if (w_ovf_q) begin
        r_ovf_sts <= 1'b1;
      end else if (i_ovf_clr) begin
        r_ovf_sts <= 1'b0;
      end
    end
  end

  assign o_cnt_clr  = w_clr;
  assign o_cnt_wren = w_wren;
  assign o_cnt_tick = w_tick;
  assign o_ovf_sts  = r_ovf_sts;
  assign o_irq      = r_ovf_sts && i_ovf_ie;
  assign o_state    = r_state;

endmodule
